// File: rtl/rhs_pkg.sv
// rtl/rhs_pkg.sv - shared opcodes, states, constants and ROM lookup for the RHS SPI responder
package rhs_pkg;

  typedef enum logic [1:0] {
    CMD_CONVERT   = 2'b00,
    CMD_CALIBRATE = 2'b01,
    CMD_WRITE     = 2'b10,
    CMD_READ      = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } frame_state_e;

  localparam int FRAME_BITS       = 32;
  localparam int REG_DEPTH        = 64;
  localparam int RESP_LATENCY     = 2;
  localparam int CONVERT_CHANNELS = 16;

  localparam logic [7:0]  ROM_ADDR_FIRST   = 8'd251;
  localparam logic [7:0]  ROM_ADDR_CHIP_ID = 8'd255;
  localparam logic [15:0] DC_BASE          = 16'h0200;

  // Read-only identification block: 'I','N','T','A' then the chip id.
  function automatic logic [15:0] rom_data(input logic [7:0] addr, input logic [15:0] chip_id);
    logic [15:0] d;
    d = '0;
    case (addr)
      8'd251:           d = 16'h0049;
      8'd252:           d = 16'h004E;
      8'd253:           d = 16'h0054;
      8'd254:           d = 16'h0041;
      ROM_ADDR_CHIP_ID: d = chip_id;
      default:          d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rhs_spi_frame_shifter.sv
// rtl/rhs_spi_frame_shifter.sv - SPI mode-0 frame capture and MISO shift-out with frame valid/abort pulses
module rhs_spi_frame_shifter
  import rhs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  input  logic [31:0] resp,
  output logic        miso,
  output logic        frame_valid,
  output logic        frame_abort,
  output logic [31:0] cmd
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  frame_state_e           state;
  logic [5:0]             bit_cnt;
  logic [31:0]            out_sr;

  // Synchronizers reset low so that a CS already held low at reset release
  // never looks like a fresh falling edge; a mid-frame reset drops that frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Frame FSM: CS edges bracket a frame; a CS rise takes priority over any SCLK edge in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd         <= '0;
      out_sr      <= '0;
      miso        <= 1'b0;
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            out_sr  <= resp;
            miso    <= resp[31];
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            miso <= 1'b0;
            if (bit_cnt == 6'(FRAME_BITS)) begin
              state       <= ST_DONE;
              frame_valid <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              frame_abort <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (bit_cnt < 6'(FRAME_BITS)) begin
              cmd <= {cmd[30:0], mosi_s};
            end
            // Saturating one past a full frame marks over-long frames as bad.
            if (bit_cnt != 6'(FRAME_BITS + 1)) begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            out_sr <= {out_sr[30:0], 1'b0};
            miso   <= out_sr[30];
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rhs_spi_responder.sv
// rtl/rhs_spi_responder.sv - RHS2116-style SPI slave: command decode, register file, CONVERT data and response pipeline
module rhs_spi_responder
  import rhs_pkg::*;
#(
  parameter logic [7:0]  STARTING_SEED = 8'd0,
  parameter logic [15:0] CHIP_ID       = 16'd32,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_strobe,
  output logic [31:0] last_cmd,
  output logic [7:0]  bad_frame_count
);

  logic        frame_valid;
  logic        frame_abort;
  logic [31:0] cmd;
  logic [15:0] regs [REG_DEPTH];
  logic [31:0] resp_pipe [RESP_LATENCY];
  logic [7:0]  sample_cnt;

  cmd_op_e     op;
  logic [7:0]  addr;
  logic [5:0]  ch;
  logic [15:0] rdata;
  logic [31:0] resp_next;
  logic        reg_we;
  logic        sample_inc;
  logic        unused_cmd_bits;

  rhs_spi_frame_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .sclk        (SCLK),
    .cs          (CS),
    .mosi        (MOSI),
    .resp        (resp_pipe[RESP_LATENCY-1]),
    .miso        (MISO),
    .frame_valid (frame_valid),
    .frame_abort (frame_abort),
    .cmd         (cmd)
  );

  assign frame_strobe    = frame_valid;
  assign unused_cmd_bits = ^cmd[29:24];

  // Decode the completed command into its response and side effects.
  always_comb begin
    op         = cmd_op_e'(cmd[31:30]);
    addr       = cmd[23:16];
    ch         = cmd[21:16];
    rdata      = '0;
    resp_next  = '0;
    reg_we     = 1'b0;
    sample_inc = 1'b0;
    if (addr < 8'(REG_DEPTH)) begin
      rdata = regs[addr[5:0]];
    end else if (addr >= ROM_ADDR_FIRST) begin
      rdata = rom_data(addr, CHIP_ID);
    end
    case (op)
      CMD_CONVERT: begin
        if (ch < 6'(CONVERT_CHANNELS)) begin
          resp_next  = {DC_BASE + {10'd0, ch}, STARTING_SEED + {2'd0, ch}, sample_cnt};
          sample_inc = (ch == '0);
        end
      end
      CMD_CALIBRATE: resp_next = '0;
      CMD_WRITE: begin
        reg_we    = (addr < 8'(REG_DEPTH));
        resp_next = {16'hFFFF, cmd[15:0]};
      end
      CMD_READ: resp_next = {16'h0000, rdata};
      default:  resp_next = '0;
    endcase
  end

  // Register file writes land at frame completion, visible to the very next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (frame_valid && reg_we) begin
      regs[addr[5:0]] <= cmd[15:0];
    end
  end

  // Response pipeline gives the two-frame latency; it only moves on valid frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        resp_pipe[i] <= '0;
      end
    end else if (frame_valid) begin
      resp_pipe[0] <= resp_next;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        resp_pipe[i] <= resp_pipe[i-1];
      end
    end
  end

  // Frame bookkeeping: last command, CONVERT sample counter, saturating bad-frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cmd        <= '0;
      sample_cnt      <= '0;
      bad_frame_count <= '0;
    end else begin
      if (frame_valid) begin
        last_cmd <= cmd;
        if (sample_inc) begin
          sample_cnt <= sample_cnt + 8'd1;
        end
      end
      if (frame_abort && bad_frame_count != 8'hFF) begin
        bad_frame_count <= bad_frame_count + 8'd1;
      end
    end
  end

endmodule
